// File: rtl/alu_result_checker.sv
// Scoreboard stage for the TinyALU: in-order expected-result FIFO, compare on dut_done, statistics.
// Optional: define ALU_CHK_HALT_ON_ERR_EN to freeze all checking at the first error until reset_n.
//
// state | meaning
// IDLE  | FIFO empty, timer idle
// WAIT  | FIFO holds at least one expected result, timer running on the head entry
// HALT  | error seen with halt-on-error built in; frozen until reset_n (optional)
module alu_result_checker #(
  parameter int DEPTH   = 8,
  parameter int RES_W   = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [RES_W-1:0]         exp_result,
  input  logic                     dut_done,
  input  logic [RES_W-1:0]         dut_result,
  output logic [CNT_W-1:0]         match_count,
  output logic [CNT_W-1:0]         mismatch_count,
  output logic [CNT_W-1:0]         timeout_count,
  output logic [CNT_W-1:0]         unexpected_count,
  output logic                     error,
  output logic [RES_W-1:0]         last_exp,
  output logic [RES_W-1:0]         last_got,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1
`ifdef ALU_CHK_HALT_ON_ERR_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t            state, state_next;
  logic [RES_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     count, cnt_next;
  logic [TW-1:0]     timer;

  logic              empty, full, halted;
  logic              push, done_act, bypass, cmp_fifo, cmp_any, unexp;
  logic              cmp_match, cmp_miss, tmo, pop, store, err_evt;
  logic [RES_W-1:0]  head, cmp_val;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));

`ifdef ALU_CHK_HALT_ON_ERR_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign push      = exp_valid && exp_ready;
  assign done_act  = dut_done && !halted;
  // Empty FIFO with a same-cycle push: compare straight against the incoming prediction.
  assign bypass    = done_act && empty && push;
  assign cmp_fifo  = done_act && !empty;
  assign unexp     = done_act && empty && !push;
  assign cmp_any   = bypass || cmp_fifo;
  assign cmp_val   = bypass ? exp_result : head;
  assign cmp_match = cmp_any && (cmp_val == dut_result);
  assign cmp_miss  = cmp_any && (cmp_val != dut_result);
  assign tmo       = (state == WAIT) && !done_act && (timer == TW'(TIMEOUT - 1));
  assign pop       = cmp_fifo || tmo;
  assign store     = push && !bypass;
  assign err_evt   = cmp_miss || tmo || unexp;
  assign cnt_next  = count + PW'(store) - PW'(pop);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WAIT: begin
`ifdef ALU_CHK_HALT_ON_ERR_EN
        if (err_evt) state_next = HALT;
        else
`endif
        state_next = (cnt_next == '0) ? IDLE : WAIT;
      end
      default: state_next = state;
    endcase
  end

  // Outputs
  always_comb begin
    exp_ready = !full && !halted;
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= exp_result;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  timer <= '0;
    else if (pop)                  timer <= '0;
    else if (state == WAIT && !done_act) timer <= timer + TW'(1);
    else if (state != WAIT)        timer <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count      <= '0;
      mismatch_count   <= '0;
      timeout_count    <= '0;
      unexpected_count <= '0;
      error            <= 1'b0;
      last_exp         <= '0;
      last_got         <= '0;
    end else begin
      if (cmp_match) match_count <= sat_inc(match_count);
      if (cmp_miss) begin
        mismatch_count <= sat_inc(mismatch_count);
        last_exp       <= cmp_val;
        last_got       <= dut_result;
      end
      if (tmo) begin
        timeout_count <= sat_inc(timeout_count);
        last_exp      <= head;
        last_got      <= '0;
      end
      if (unexp) begin
        unexpected_count <= sat_inc(unexpected_count);
        last_got         <= dut_result;
      end
      if (err_evt) error <= 1'b1;
    end
  end

  assign pending = count;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed self-checking bench for alu_result_checker (default parameters).
// Build with ALU_CHK_HALT_ON_ERR_EN defined to exercise the halt-on-error variant.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exp_valid;
  logic        exp_ready;
  logic [15:0] exp_result;
  logic        dut_done;
  logic [15:0] dut_result;
  logic [15:0] match_count, mismatch_count, timeout_count, unexpected_count;
  logic        error;
  logic [15:0] last_exp, last_got;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_checker #(.DEPTH(8), .RES_W(16), .CNT_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_result(exp_result),
    .dut_done(dut_done), .dut_result(dut_result),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .timeout_count(timeout_count), .unexpected_count(unexpected_count),
    .error(error), .last_exp(last_exp), .last_got(last_got), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exp_valid = 1'b0; exp_result = '0; dut_done = 1'b0; dut_result = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [15:0] v);
    exp_valid = 1'b1; exp_result = v;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic done(input logic [15:0] v);
    dut_done = 1'b1; dut_result = v;
    step();
    dut_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if (exp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", exp_ready); end
    n_checks++;
    if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    n_checks++;
    if ({match_count, mismatch_count, timeout_count, unexpected_count} !== 64'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h expected 0", {match_count, mismatch_count, timeout_count, unexpected_count});
    end
    n_checks++;
    if ({error, last_exp, last_got} !== 33'd0) begin
      n_fail++; $display("FAIL reset_err_last: got %h expected 0", {error, last_exp, last_got});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_match();
    do_reset();
    push(16'h0005);
    push(16'h00A0);
    n_checks++;
    if (pending !== 4'd2) begin n_fail++; $display("FAIL match_pending2: got %0d expected 2", pending); end
    done(16'h0005);
    done(16'h00A0);
    n_checks++;
    if (match_count !== 16'd2) begin n_fail++; $display("FAIL match_count: got %0d expected 2", match_count); end
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL match_error: got %b expected 0", error); end
    n_checks++;
    if (pending !== 4'd0) begin n_fail++; $display("FAIL match_pending0: got %0d expected 0", pending); end
  endtask

  task automatic test_mismatch();
    do_reset();
    push(16'h1234);
    done(16'h1235);
    n_checks++;
    if (mismatch_count !== 16'd1) begin n_fail++; $display("FAIL mis_count: got %0d expected 1", mismatch_count); end
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL mis_error: got %b expected 1", error); end
    n_checks++;
    if (last_exp !== 16'h1234) begin n_fail++; $display("FAIL mis_last_exp: got %h expected 1234", last_exp); end
    n_checks++;
    if (last_got !== 16'h1235) begin n_fail++; $display("FAIL mis_last_got: got %h expected 1235", last_got); end
    n_checks++;
    if (match_count !== 16'd0) begin n_fail++; $display("FAIL mis_match_count: got %0d expected 0", match_count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
    n_checks++;
    if (pending !== 4'd8) begin n_fail++; $display("FAIL full_pending: got %0d expected 8", pending); end
    n_checks++;
    if (exp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", exp_ready); end
    // Push attempt while full must be refused; the done still pops the head.
    exp_valid = 1'b1; exp_result = 16'h0099;
    dut_done = 1'b1; dut_result = 16'h0010;
    step();
    idle_inputs();
    n_checks++;
    if (pending !== 4'd7) begin n_fail++; $display("FAIL full_pending7: got %0d expected 7", pending); end
    n_checks++;
    if (exp_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after: got %b expected 1", exp_ready); end
    for (int i = 1; i < 8; i++) done(16'h0010 + 16'(i));
    n_checks++;
    if (match_count !== 16'd8 || mismatch_count !== 16'd0) begin
      n_fail++; $display("FAIL full_drain: got match %0d mismatch %0d expected 8 0", match_count, mismatch_count);
    end
    n_checks++;
    if (pending !== 4'd0) begin n_fail++; $display("FAIL full_drain_pending: got %0d expected 0", pending); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(16'h0AAA);
    exp_valid = 1'b1; exp_result = 16'h0BBB;
    dut_done = 1'b1; dut_result = 16'h0AAA;
    step();
    idle_inputs();
    n_checks++;
    if (pending !== 4'd1 || match_count !== 16'd1) begin
      n_fail++; $display("FAIL b2b_first: got pending %0d match %0d expected 1 1", pending, match_count);
    end
    done(16'h0BBB);
    n_checks++;
    if (pending !== 4'd0 || match_count !== 16'd2 || error !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got pending %0d match %0d err %b expected 0 2 0", pending, match_count, error);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push(16'h00FF);
    for (int i = 0; i < 63; i++) step();
    n_checks++;
    if (timeout_count !== 16'd0 || pending !== 4'd1) begin
      n_fail++; $display("FAIL tmo_early: got tmo %0d pending %0d expected 0 1", timeout_count, pending);
    end
    step();
    n_checks++;
    if (timeout_count !== 16'd1) begin n_fail++; $display("FAIL tmo_count: got %0d expected 1", timeout_count); end
    n_checks++;
    if (pending !== 4'd0 || error !== 1'b1) begin
      n_fail++; $display("FAIL tmo_state: got pending %0d err %b expected 0 1", pending, error);
    end
    n_checks++;
    if (last_exp !== 16'h00FF || last_got !== 16'h0000) begin
      n_fail++; $display("FAIL tmo_last: got %h/%h expected 00ff/0000", last_exp, last_got);
    end
    do_reset();
    push(16'h00FF);
    for (int i = 0; i < 63; i++) step();
    done(16'h00FF);
    step();
    n_checks++;
    if (match_count !== 16'd1 || timeout_count !== 16'd0 || error !== 1'b0) begin
      n_fail++; $display("FAIL tmo_edge_done: got match %0d tmo %0d err %b expected 1 0 0", match_count, timeout_count, error);
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    done(16'h0042);
    n_checks++;
    if (unexpected_count !== 16'd1 || error !== 1'b1) begin
      n_fail++; $display("FAIL unexp_count: got %0d err %b expected 1 1", unexpected_count, error);
    end
    n_checks++;
    if (last_got !== 16'h0042) begin n_fail++; $display("FAIL unexp_last_got: got %h expected 0042", last_got); end
    exp_valid = 1'b1; exp_result = 16'h0042;
    dut_done = 1'b1; dut_result = 16'h0042;
    step();
    idle_inputs();
    n_checks++;
    if (match_count !== 16'd1 || pending !== 4'd0 || unexpected_count !== 16'd1) begin
      n_fail++; $display("FAIL bypass: got match %0d pending %0d unexp %0d expected 1 0 1", match_count, pending, unexpected_count);
    end
    step();
    n_checks++;
    if (timeout_count !== 16'd0 || pending !== 4'd0) begin
      n_fail++; $display("FAIL bypass_nostore: got tmo %0d pending %0d expected 0 0", timeout_count, pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(16'h0001);
    push(16'h0002);
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (pending !== 4'd0) begin n_fail++; $display("FAIL rst_mid_pending: got %0d expected 0", pending); end
    reset_n = 1'b1;
    step();
    done(16'h0001);
    n_checks++;
    if (unexpected_count !== 16'd1 || match_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_unexp: got unexp %0d match %0d expected 1 0", unexpected_count, match_count);
    end
  endtask

`ifdef ALU_CHK_HALT_ON_ERR_EN
  task automatic test_halt();
    do_reset();
    push(16'h1234);
    done(16'h1235);
    n_checks++;
    if (exp_ready !== 1'b0 || mismatch_count !== 16'd1) begin
      n_fail++; $display("FAIL halt_enter: got ready %b mis %0d expected 0 1", exp_ready, mismatch_count);
    end
    push(16'h0007);
    done(16'h0007);
    done(16'h0009);
    n_checks++;
    if (match_count !== 16'd0 || mismatch_count !== 16'd1 || unexpected_count !== 16'd0 || pending !== 4'd0) begin
      n_fail++; $display("FAIL halt_frozen: got match %0d mis %0d unexp %0d pending %0d expected 0 1 0 0",
                         match_count, mismatch_count, unexpected_count, pending);
    end
    n_checks++;
    if (last_exp !== 16'h1234 || last_got !== 16'h1235) begin
      n_fail++; $display("FAIL halt_last: got %h/%h expected 1234/1235", last_exp, last_got);
    end
    do_reset();
    n_checks++;
    if (exp_ready !== 1'b1 || mismatch_count !== 16'd0 || error !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset: got ready %b mis %0d err %b expected 1 0 0", exp_ready, mismatch_count, error);
    end
  endtask
`else
  task automatic test_no_halt();
    do_reset();
    push(16'h1234);
    done(16'h1235);
    n_checks++;
    if (exp_ready !== 1'b1) begin n_fail++; $display("FAIL nohalt_ready: got %b expected 1", exp_ready); end
    push(16'h0007);
    done(16'h0007);
    n_checks++;
    if (match_count !== 16'd1 || mismatch_count !== 16'd1 || error !== 1'b1) begin
      n_fail++; $display("FAIL nohalt_continue: got match %0d mis %0d err %b expected 1 1 1", match_count, mismatch_count, error);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b1;
    idle_inputs();
    test_reset();
    test_match();
    test_mismatch();
    test_full();
    test_back_to_back();
    test_timeout();
    test_unexpected();
    test_reset_mid();
`ifdef ALU_CHK_HALT_ON_ERR_EN
    test_halt();
`else
    test_no_halt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
